// File: rtl/edge_capture_unit.sv
// Edge capture unit: per-channel edge detection with a shared detection mode,
// one-cycle edge pulses, sticky edge flags and saturating per-channel edge
// counters, one of which is selected onto the count output.
module edge_capture_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic [SEL_W-1:0] ch_sel,
    output logic [WIDTH-1:0] edge_out,
    output logic [WIDTH-1:0] sticky,
    output logic [CNT_W-1:0] count,
    output logic             any_event
);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_next;
    logic [CNT_W-1:0] counter [WIDTH];

    // Select which transitions are reported this clock; nothing before priming.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        edge_next = '0;
        rise      = in & ~prev;
        fall      = ~in & prev;
        if (primed) begin
            case (mode)
                MODE_RISE: edge_next = rise;
                MODE_FALL: edge_next = fall;
                MODE_BOTH: edge_next = rise | fall;
                default:   edge_next = '0;
            endcase
        end
    end

    // Track the previous input level, prime after reset, register the pulses.
    // prev keeps following in even while detection is disabled, so re-enabling
    // never reports a stale transition; clr deliberately does not touch these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            primed   <= 1'b0;
            edge_out <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            prev     <= in;
            primed   <= 1'b1;
            edge_out <= edge_next;
        end
    end

    // Latch edges into sticky flags and saturating counters; clr wins over an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
            // NOTE: the counter array is small and must read zero during reset, so it is reset like any register rather than left as uninitialised storage.
            for (int i = 0; i < WIDTH; i++) begin
                counter[i] <= '0;
            end
        end else if (clr) begin
            sticky <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                counter[i] <= '0;
            end
        end else begin
            sticky <= sticky | edge_next;
            for (int i = 0; i < WIDTH; i++) begin
                if (edge_next[i] && (counter[i] != CNT_MAX)) begin
                    counter[i] <= counter[i] + CNT_ONE;
                end
            end
        end
    end

    // Drive the selected channel's counter; out-of-range selections read zero.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                count = counter[i];
            end
        end
    end

    assign any_event = |edge_out;

endmodule

// File: doc/edge_capture_unit.md
EDGE_CAPTURE_UNIT -- requirements
Module: edge_capture_unit

Interface
REQ-001 Parameter: WIDTH, default 8, number of independent input channels (1..32).
REQ-002 Parameter: CNT_W, default 8, width of each per-channel edge counter (2..16).
REQ-003 Parameter: SEL_W, default 3, width of ch_sel; SEL_W SHALL equal clog2(WIDTH), minimum 1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  WIDTH  channel inputs; SHALL be synchronous to clk.
REQ-007 mode  input  2  detection mode, shared by all channels: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-008 clr  input  1  synchronous clear of sticky flags and counters.
REQ-009 ch_sel  input  SEL_W  channel whose counter drives count.
REQ-010 edge_out  output  WIDTH  one-cycle per-channel edge pulse.
REQ-011 sticky  output  WIDTH  per-channel latched edge flag.
REQ-012 count  output  CNT_W  edge counter of channel ch_sel.
REQ-013 any_event  output  1  OR-reduction of edge_out.

Function
REQ-014 The block SHALL register in into prev on every clock, and SHALL form rise = in & ~prev and fall = ~in & prev.
REQ-015 At each clock, edge_out SHALL load rise (mode 00), fall (01), rise|fall (10), or zero (11), using the mode value sampled at that edge.
REQ-016 Latency: an input change sampled at posedge k SHALL give edge_out high from posedge k to posedge k+1; each input transition SHALL produce exactly one pulse of one cycle.
REQ-017 A primed flag SHALL be 0 out of reset and SHALL set at the first clock after reset release; while primed is 0, edge_out SHALL load zero, so an input level present at reset release is never reported as an edge.
REQ-018 At each clock with clr=0, sticky[i] SHALL set when the value loaded into edge_out[i] is 1, and SHALL stay set until clr or reset.
REQ-019 At each clock with clr=0, counter[i] SHALL increment by 1 when the value loaded into edge_out[i] is 1.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap to zero.
REQ-021 With clr=1, all sticky bits and counters SHALL go to 0 at that clock.
REQ-022 clr SHALL win over a simultaneous edge: that edge is not counted and not stickied, but its edge_out pulse SHALL still be produced.
REQ-023 clr SHALL NOT affect prev, primed or edge_out.
REQ-024 count SHALL be combinational: count = counter[ch_sel].
REQ-025 count SHALL be 0 when ch_sel >= WIDTH.
REQ-026 any_event SHALL be combinational: any_event = |edge_out.
REQ-027 A mode change SHALL affect only detections at or after the clock that samples the new mode; edge_out SHALL NOT be recomputed retroactively.
REQ-028 In mode 11, prev SHALL keep tracking in, so re-enabling a mode SHALL NOT report a stale transition.
REQ-029 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported and counted in the same cycle.

Reset
REQ-030 While rst_n=0, prev, primed, edge_out, sticky and all counters SHALL be 0, and hence count=0 and any_event=0.
REQ-031 Reset SHALL take effect immediately on rst_n falling, independent of clk, including in the middle of a pulse or count.
REQ-032 Reset release SHALL be treated as synchronous to clk; the first posedge after release primes the block per REQ-017.

Verification
REQ-033 WIDTH=8, mode=00, in held at 0 for 2 cycles, then 0x02 for 4 cycles, 0x0E for 3, 0x02 for 4 -> edge_out=0x02 for exactly one cycle, later 0x0C for one cycle, otherwise 0x00; final sticky=0x0E; count with ch_sel=1 is 1, with ch_sel=2 is 1.
REQ-034 Same stimulus with mode=01 -> edge_out=0x0C for one cycle at the 0x0E->0x02 step only; sticky=0x0C. With mode=10 -> pulses 0x02, 0x0C, 0x0C; count for ch_sel=2 is 2.
REQ-035 in=0xFF held through reset and after release -> edge_out stays 0x00 and sticky stays 0x00.
REQ-036 CNT_W=2, channel 0 toggled 10 times in mode 10 -> count with ch_sel=0 reads 3 and stays 3. Then clr asserted in the same cycle as another edge -> edge_out[0] pulses, count=0, sticky[0]=0.
REQ-037 rst_n driven low between clock edges mid-pulse -> edge_out, sticky and count go to 0 before the next posedge.
REQ-038 mode=11 with toggling inputs -> edge_out stays 0x00. Switching to mode 00 while in is stable at 0x0F -> no pulse; the next 0x0F->0x1F step -> edge_out=0x10 for one cycle.
